stopwatch_btn_cond: RTL

//  Input conditioning stage that feeds the stopwatch controller FSM.
//  - Synchronises, debounces and edge-detects the reset (R) and pause/start (P) push-buttons.
//  - Synchronises the mode-select (sel) and preload (load) slide switches.
//  - Emits one-cycle R/P command pulses plus stable switch values.

---
 rtl/stopwatch_btn_cond_pkg.sv | 20 ++
 rtl/stopwatch_btn_cond_debounce.sv | 95 +++++++++
 rtl/stopwatch_btn_cond.sv | 107 ++++++++++
 3 files changed

// File: rtl/stopwatch_btn_cond_pkg.sv
// Shared encodings and default timing constants for the stopwatch input conditioning stage.
// Debounce state codes are fixed so that they match the downstream controller's view of the buttons.
package stopwatch_btn_cond_pkg;

    typedef enum logic [1:0] {
        DB_IDLE         = 2'b00,
        DB_PRESS_WAIT   = 2'b01,
        DB_HELD         = 2'b10,
        DB_RELEASE_WAIT = 2'b11
    } db_state_t;

    localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;
    localparam int LONG_CYCLES_DEF     = 200_000_000;

    // One counter width serves both the debounce and long-press timers.
    function automatic int cnt_width(input int a, input int b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

endpackage

// File: rtl/stopwatch_btn_cond_debounce.sv
// Per-button conditioner: 2-flop synchroniser, debounce FSM and saturating qualify counter.
// Emits the debounced level, a one-cycle accept pulse, and a flag for the HELD state.
//
// state            | meaning
// DB_IDLE          | button released and qualified
// DB_PRESS_WAIT    | input high, counting stable samples toward acceptance
// DB_HELD          | press accepted, level high
// DB_RELEASE_WAIT  | input low, counting stable samples toward release
module stopwatch_btn_cond_debounce
    import stopwatch_btn_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int LONG_CYCLES     = LONG_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic pulse,
    output logic held
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, LONG_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic             sync_q1;
    logic             sync_q2;
    db_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;

    // The first high sample seen in IDLE counts as sample one of the window.
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    assign held    = (state == DB_HELD);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            state   <= DB_IDLE;
            cnt     <= '0;
            level   <= 1'b0;
            pulse   <= 1'b0;
        end else begin
            sync_q1 <= btn;
            sync_q2 <= sync_q1;
            pulse   <= 1'b0;
            case (state)
                DB_IDLE: begin
                    if (sync_q2) begin
                        state <= DB_PRESS_WAIT;
                        cnt   <= '0;
                    end
                end
                DB_PRESS_WAIT: begin
                    if (!sync_q2) begin
                        state <= DB_IDLE;
                        cnt   <= '0;
                    end else if (cnt_inc == CNT_LAST) begin
                        state <= DB_HELD;
                        level <= 1'b1;
                        pulse <= 1'b1;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                DB_HELD: begin
                    if (!sync_q2) begin
                        state <= DB_RELEASE_WAIT;
                        cnt   <= '0;
                    end
                end
                DB_RELEASE_WAIT: begin
                    if (sync_q2) begin
                        state <= DB_HELD;
                        cnt   <= '0;
                    end else if (cnt_inc == CNT_LAST) begin
                        state <= DB_IDLE;
                        level <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: begin
                    state <= DB_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/stopwatch_btn_cond.sv
// Stopwatch input conditioning: debounced R/P command pulses and synchronised switches.
// Define BTN_LONGPRESS_EN to let a long P hold issue one extra r_pulse.
module stopwatch_btn_cond
    import stopwatch_btn_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int LONG_CYCLES     = LONG_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_r,
    input  logic       btn_p,
    input  logic [1:0] sw_sel,
    input  logic [7:0] sw_load,
    output logic       r_pulse,
    output logic       p_pulse,
    output logic       r_level,
    output logic       p_level,
    output logic [1:0] sel,
    output logic [7:0] load
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, LONG_CYCLES);

    logic       r_pulse_db;
    logic       r_held_unused;
    logic       p_held;
    logic [1:0] sel_q1;
    logic [7:0] load_q1;

    stopwatch_btn_cond_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .LONG_CYCLES     (LONG_CYCLES)
    ) u_db_r (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_r),
        .level (r_level),
        .pulse (r_pulse_db),
        .held  (r_held_unused)
    );

    stopwatch_btn_cond_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .LONG_CYCLES     (LONG_CYCLES)
    ) u_db_p (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_p),
        .level (p_level),
        .pulse (p_pulse),
        .held  (p_held)
    );

    // Switches are slow and level-only, so a plain 2-flop sync is enough.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q1  <= '0;
            load_q1 <= '0;
            sel     <= '0;
            load    <= '0;
        end else begin
            sel_q1  <= sw_sel;
            load_q1 <= sw_load;
            sel     <= sel_q1;
            load    <= load_q1;
        end
    end

`ifdef BTN_LONGPRESS_EN
    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] LP_MAX  = '1;

    logic [CNT_W-1:0] lp_cnt;
    logic             lp_pulse;

    // Saturating count means the terminal compare matches once per hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            lp_cnt   <= '0;
            lp_pulse <= 1'b0;
        end else begin
            lp_pulse <= 1'b0;
            if (!p_held) begin
                lp_cnt <= '0;
            end else begin
                if (lp_cnt != LP_MAX) begin
                    lp_cnt <= lp_cnt + 1'b1;
                end
                if (lp_cnt == LP_LAST) begin
                    lp_pulse <= 1'b1;
                end
            end
        end
    end

    assign r_pulse = r_pulse_db | lp_pulse;
`else
    logic unused_p_held;
    logic [CNT_W-1:0] unused_cnt_w;

    assign unused_p_held = p_held;
    assign unused_cnt_w  = '0;
    assign r_pulse       = r_pulse_db;
`endif

endmodule
